// File: rtl/writeback_regfile_if.sv
// Bundle between the memory stage, decode and the write-back/register-file block.
// The slave modport is the write-back block; the master side drives the M fields and read addresses.
interface writeback_regfile_if #(
  parameter int CNT_W = 32
);
  logic [3:0]       M_stat;
  logic [3:0]       M_icode;
  logic [63:0]      M_valE;
  logic [63:0]      m_valM;
  logic [3:0]       M_dstE;
  logic [3:0]       M_dstM;
  logic             W_stall;
  logic             W_bubble;
  logic [3:0]       srcA;
  logic [3:0]       srcB;
  logic [63:0]      rvalA;
  logic [63:0]      rvalB;
  logic [3:0]       W_stat;
  logic [3:0]       W_icode;
  logic [63:0]      W_valE;
  logic [63:0]      W_valM;
  logic [3:0]       W_dstE;
  logic [3:0]       W_dstM;
  logic [3:0]       Stat;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    output M_stat, M_icode, M_valE, m_valM, M_dstE, M_dstM,
    output W_stall, W_bubble, srcA, srcB,
    input  rvalA, rvalB, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM,
    input  Stat, halted, retired
  );

  modport slave (
    input  M_stat, M_icode, M_valE, m_valM, M_dstE, M_dstM,
    input  W_stall, W_bubble, srcA, srcB,
    output rvalA, rvalB, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM,
    output Stat, halted, retired
  );
endinterface

// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage: W pipeline register, 15 x 64-bit register file with two
// combinational read ports, sticky halt flag, architectural status and retired counter.
module writeback_regfile #(
  parameter logic [63:0] STACK_TOP = 64'd2047,
  parameter int          CNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  writeback_regfile_if.slave bus
);

  typedef enum logic [3:0] {
    STAT_BUB = 4'd0,
    STAT_AOK = 4'd1,
    STAT_HLT = 4'd2,
    STAT_ADR = 4'd3,
    STAT_INS = 4'd4
  } stat_e;

  localparam logic [3:0] REG_NONE   = 4'hF;
  localparam logic [3:0] REG_RSP    = 4'd4;
  localparam logic [3:0] ICODE_NOP  = 4'd1;
  localparam int         NUM_REGS   = 15;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } w_reg_t;

  localparam w_reg_t W_BUBBLE = '{
    stat:  STAT_BUB,
    icode: ICODE_NOP,
    val_e: 64'd0,
    val_m: 64'd0,
    dst_e: REG_NONE,
    dst_m: REG_NONE
  };

  w_reg_t           w_q;
  w_reg_t           w_next;
  logic             load_w;
  logic             commit;
  logic             committed;
  logic             halted;
  logic             exc_in_w;
  logic [CNT_W-1:0] retired;
  logic [63:0]      regs [NUM_REGS];

  // Halted freezes W exactly like a stall; bubble only matters when W is free to load.
  assign load_w   = !halted && !bus.W_stall;
  assign exc_in_w = (w_q.stat == STAT_HLT) || (w_q.stat == STAT_ADR) || (w_q.stat == STAT_INS);
  assign commit   = (w_q.stat == STAT_AOK) && !halted && !committed;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_next = w_q;
    if (load_w) begin
      if (bus.W_bubble) begin
        w_next = W_BUBBLE;
      end else begin
        w_next.stat  = bus.M_stat;
        w_next.icode = bus.M_icode;
        w_next.val_e = bus.M_valE;
        w_next.val_m = bus.m_valM;
        w_next.dst_e = bus.M_dstE;
        w_next.dst_m = bus.M_dstM;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_q <= W_BUBBLE;
    end else begin
      w_q <= w_next;
    end
  end

  // A held instruction commits once; the flag clears whenever W takes a new instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      committed <= 1'b0;
    end else if (load_w) begin
      committed <= 1'b0;
    end else if (commit) begin
      committed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      halted <= 1'b0;
    end else if (exc_in_w) begin
      halted <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired <= '0;
    end else if (commit) begin
      retired <= retired + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the register array is reset entry by entry because %rsp must come up at STACK_TOP, not zero.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == int'(REG_RSP)) ? STACK_TOP : 64'd0;
      end
    end else if (commit) begin
      if (w_q.dst_e != REG_NONE) begin
        regs[w_q.dst_e] <= w_q.val_e;
      end
      // Issued last so valM wins when both destinations match (popq %rsp).
      if (w_q.dst_m != REG_NONE) begin
        regs[w_q.dst_m] <= w_q.val_m;
      end
    end
  end

  // No internal bypass: decode forwards from the W_* outputs itself.
  assign bus.rvalA = (bus.srcA == REG_NONE) ? 64'd0 : regs[bus.srcA];
  assign bus.rvalB = (bus.srcB == REG_NONE) ? 64'd0 : regs[bus.srcB];

  assign bus.W_stat  = w_q.stat;
  assign bus.W_icode = w_q.icode;
  assign bus.W_valE  = w_q.val_e;
  assign bus.W_valM  = w_q.val_m;
  assign bus.W_dstE  = w_q.dst_e;
  assign bus.W_dstM  = w_q.dst_m;
  assign bus.Stat    = (w_q.stat == STAT_BUB) ? STAT_AOK : w_q.stat;
  assign bus.halted  = halted;
  assign bus.retired = retired;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: expected register contents are queued when an
// instruction is driven and compared through the read ports once it should have committed.
module tb_writeback_regfile;

  localparam int CNT_W = 32;

  logic clk;
  logic reset;

  writeback_regfile_if #(.CNT_W(CNT_W)) bus ();

  writeback_regfile #(
    .STACK_TOP(64'd2047),
    .CNT_W    (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    string       tag;
    logic [3:0]  addr;
    logic [63:0] value;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int        checks;
  int        errors;
  logic [CNT_W-1:0] exp_retired;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input logic [3:0] stat, input logic [63:0] val_e, input logic [63:0] val_m,
                         input logic [3:0] dst_e, input logic [3:0] dst_m);
    bus.M_stat  = stat;
    bus.M_icode = 4'd6;
    bus.M_valE  = val_e;
    bus.m_valM  = val_m;
    bus.M_dstE  = dst_e;
    bus.M_dstM  = dst_m;
  endtask

  task automatic drive_bubble();
    drive_m(4'd0, 64'd0, 64'd0, 4'hF, 4'hF);
  endtask

  task automatic sb_expect(input string tag, input logic [3:0] addr, input logic [63:0] value);
    sb_entry_t e;
    e.tag   = tag;
    e.addr  = addr;
    e.value = value;
    sb_q.push_back(e);
  endtask

  task automatic sb_drain();
    sb_entry_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus.srcA = e.addr;
      bus.srcB = e.addr;
      #1;
      check(e.tag, bus.rvalA, e.value);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    exp_retired = '0;
    reset        = 1'b1;
    bus.W_stall  = 1'b0;
    bus.W_bubble = 1'b0;
    bus.srcA     = 4'd4;
    bus.srcB     = 4'd0;
    drive_bubble();
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state.
    check("rst_rsp", bus.rvalA, 64'd2047);
    check("rst_r0", bus.rvalB, 64'd0);
    check("rst_stat", {60'd0, bus.Stat}, 64'd1);
    check("rst_halted", {63'd0, bus.halted}, 64'd0);
    check("rst_retired", {32'd0, bus.retired}, 64'd0);
    check("rst_w_stat", {60'd0, bus.W_stat}, 64'd0);
    check("rst_w_icode", {60'd0, bus.W_icode}, 64'd1);
    check("rst_w_dste", {60'd0, bus.W_dstE}, 64'd15);
    bus.srcA = 4'hF;
    #1;
    check("rd_none", bus.rvalA, 64'd0);

    // Simple AOK write to r3: visible in W after N, in the file after N+1.
    drive_m(4'd1, 64'h1234, 64'd0, 4'd3, 4'hF);
    sb_expect("wr_r3", 4'd3, 64'h1234);
    exp_retired++;
    tick();
    bus.srcA = 4'd3;
    #1;
    check("w_dste_r3", {60'd0, bus.W_dstE}, 64'd3);
    check("no_bypass_r3", bus.rvalA, 64'd0);
    drive_bubble();
    tick();
    sb_drain();
    check("retired_1", {32'd0, bus.retired}, {32'd0, exp_retired});

    // popq %rsp: valM wins over valE on the shared destination.
    drive_m(4'd1, 64'd2055, 64'hAB, 4'd4, 4'd4);
    sb_expect("popq_rsp", 4'd4, 64'hAB);
    exp_retired++;
    tick();
    drive_bubble();
    tick();
    sb_drain();

    // Distinct E and M destinations both written.
    drive_m(4'd1, 64'h8888, 64'h9999, 4'd8, 4'd9);
    sb_expect("dual_r8", 4'd8, 64'h8888);
    sb_expect("dual_r9", 4'd9, 64'h9999);
    exp_retired++;
    tick();
    drive_bubble();
    tick();
    sb_drain();
    check("retired_3", {32'd0, bus.retired}, {32'd0, exp_retired});

    // Stall held three edges over an AOK write to r7; the next instruction waits in M.
    drive_m(4'd1, 64'h77, 64'd0, 4'd7, 4'hF);
    sb_expect("stall_r7", 4'd7, 64'h77);
    sb_expect("stall_r10_untouched", 4'd10, 64'd0);
    exp_retired++;
    tick();
    bus.W_stall = 1'b1;
    drive_m(4'd1, 64'hAAAA, 64'd0, 4'd10, 4'hF);
    tick();
    tick();
    tick();
    check("stall_retired", {32'd0, bus.retired}, {32'd0, exp_retired});
    check("stall_w_hold", {60'd0, bus.W_dstE}, 64'd7);
    drive_bubble();
    bus.W_stall = 1'b0;
    tick();
    sb_drain();

    // Bubble: W shows stat 0, Stat reports AOK, nothing written or counted.
    drive_m(4'd1, 64'hBBBB, 64'd0, 4'd11, 4'hF);
    bus.W_bubble = 1'b1;
    sb_expect("bubble_r11", 4'd11, 64'd0);
    tick();
    check("bubble_w_stat", {60'd0, bus.W_stat}, 64'd0);
    check("bubble_stat", {60'd0, bus.Stat}, 64'd1);
    bus.W_bubble = 1'b0;
    drive_bubble();
    tick();
    sb_drain();
    check("bubble_retired", {32'd0, bus.retired}, {32'd0, exp_retired});

    // Stall and bubble together: stall wins, held instruction commits once.
    drive_m(4'd1, 64'hC0C0, 64'd0, 4'd12, 4'hF);
    sb_expect("stall_bub_r12", 4'd12, 64'hC0C0);
    exp_retired++;
    tick();
    bus.W_stall  = 1'b1;
    bus.W_bubble = 1'b1;
    drive_bubble();
    tick();
    tick();
    check("stall_bub_w", {60'd0, bus.W_dstE}, 64'd12);
    bus.W_stall  = 1'b0;
    bus.W_bubble = 1'b0;
    tick();
    sb_drain();
    check("stall_bub_retired", {32'd0, bus.retired}, {32'd0, exp_retired});

    // HLT with dstE=5: no write; W held by control while the exception sits in W.
    drive_m(4'd2, 64'h5555, 64'd0, 4'd5, 4'hF);
    sb_expect("hlt_r5", 4'd5, 64'd0);
    sb_expect("hlt_r6", 4'd6, 64'd0);
    tick();
    check("hlt_stat", {60'd0, bus.Stat}, 64'd2);
    check("hlt_not_yet", {63'd0, bus.halted}, 64'd0);
    bus.W_stall = 1'b1;
    drive_m(4'd1, 64'h6666, 64'd0, 4'd6, 4'hF);
    tick();
    check("hlt_halted", {63'd0, bus.halted}, 64'd1);
    bus.W_stall = 1'b0;
    tick();
    tick();
    check("hlt_frozen_stat", {60'd0, bus.Stat}, 64'd2);
    check("hlt_halted_sticky", {63'd0, bus.halted}, 64'd1);
    check("hlt_retired", {32'd0, bus.retired}, {32'd0, exp_retired});
    sb_drain();

    // Reset while halted restores everything.
    drive_bubble();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_retired = '0;
    check("rerst_halted", {63'd0, bus.halted}, 64'd0);
    check("rerst_retired", {32'd0, bus.retired}, 64'd0);
    check("rerst_stat", {60'd0, bus.Stat}, 64'd1);
    sb_expect("rerst_rsp", 4'd4, 64'd2047);
    sb_expect("rerst_r3", 4'd3, 64'd0);
    sb_drain();
    drive_m(4'd1, 64'h6161, 64'd0, 4'd6, 4'hF);
    sb_expect("post_rst_r6", 4'd6, 64'h6161);
    exp_retired++;
    tick();
    drive_bubble();
    tick();
    sb_drain();
    check("post_rst_retired", {32'd0, bus.retired}, {32'd0, exp_retired});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Write-back end of the pipelined Y86-64 datapath: W pipeline register, 15-entry 64-bit register file and processor status/halt logic.
- Latches memory-stage results each cycle and commits valE/valM to the register file at the end of the W cycle.
- Serves two asynchronous read ports (srcA/srcB) to decode, which performs its own forwarding.
- Exports W_* fields for decode forwarding and the architectural Stat.

Parameters:
- STACK_TOP, 2047, reset value of %rsp (register 4).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- M_stat  input  4  status of instruction in M (0 BUB, 1 AOK, 2 HLT, 3 ADR, 4 INS)
- M_icode  input  4  icode in M
- M_valE  input  64  ALU result in M
- m_valM  input  64  memory read data from M
- M_dstE  input  4  E-destination register in M (15 = none)
- M_dstM  input  4  M-destination register in M (15 = none)
- W_stall  input  1  hold W register contents
- W_bubble  input  1  load bubble into W
- srcA  input  4  decode read address A
- srcB  input  4  decode read address B
- rvalA  output  64  register file value at srcA
- rvalB  output  64  register file value at srcB
- W_stat, W_icode  output  4 each  W register fields
- W_valE, W_valM  output  64 each  W register fields
- W_dstE, W_dstM  output  4 each  W register fields
- Stat  output  4  architectural status
- halted  output  1  sticky halt flag
- retired  output  CNT_W  count of committed AOK instructions

Behaviour:
- Reset (reset=1 at edge): regs 0–14 = 0 except reg4 = STACK_TOP. W register = bubble (stat 0, icode 1, valE/valM 0, dstE/dstM 15). halted = 0, retired = 0. Reset overrides stall, bubble and halted.
- W register update, per edge, in priority order:
  - reset.
  - halted=1 or W_stall=1: hold.
  - W_bubble=1: load bubble.
  - otherwise: load M_* / m_valM.
  - W_stall and W_bubble both high: stall wins.
- Commit condition: W_stat == 1 (AOK) and halted == 0.
- On a committing edge:
  - reg[W_dstE] <= W_valE when W_dstE != 15.
  - reg[W_dstM] <= W_valM when W_dstM != 15.
  - If W_dstE == W_dstM != 15, W_valM wins (popq %rsp).
  - retired increments by 1 and wraps at 2^CNT_W.
- Write latency: an instruction loaded into W at edge N commits at edge N+1. Reads reflect it combinationally after edge N+1.
- No internal write-to-read bypass. Decode forwards from W_* outputs.
- Read ports are combinational. srcX == 15 returns 0; registers 0–14 return stored value.
- Non-AOK status:
  - W_stat in {2,3,4}: no register write, no count.
  - halted sets at the next edge and stays set until reset.
  - W_stat == 0 (bubble): no write, no count, no halt.
- Stat:
  - Combinational from W_stat; bubble (0) reports 1 (AOK).
  - Once halted, Stat holds the status of the halting instruction (frozen W register).
- A stall in the same cycle as a committing instruction still commits once. Held contents do not re-commit on later stalled edges: track a committed bit, cleared when a new W load occurs.

Test Plan:
- Reset -> rvalA(srcA=4) = 2047; rvalB(srcB=0) = 0; Stat = 1; halted = 0; retired = 0.
- M_dstE=3, M_valE=0x1234, M_stat=1 at edge N -> W_dstE=3 after N; rvalA(srcA=3) = 0x1234 after N+1; retired = 1.
- popq %rsp: dstE=4, valE=2055, dstM=4, valM=0xAB, stat AOK -> reg4 = 0xAB after commit.
- M_stat=2 (HLT), dstE=5 -> reg5 unchanged; halted=1 at next edge; Stat = 2. A following AOK write to reg6 is ignored; retired unchanged.
- W_stall held 3 cycles over an AOK write to reg7 -> single write; retired increments by exactly 1. W_bubble -> W_stat = 0, Stat = 1, no write.
- reset asserted while halted=1 -> halted=0; regs restored to reset values; subsequent AOK writes commit.
